mem_block_xfer: RTL and testbench

- Block-transfer controller between the cache refill/writeback logic (upstream) and the word-serial main memory port (downstream).
- Accepts one whole-block request at a time: either a read (fill) or a write (writeback).
- Splits the request into WORDS_PER_BLOCK word accesses on the memory port.
- For reads, reassembles the returned words into a single line and hands it back upstream with a valid/ready handshake.

---
 rtl/mem_block_xfer.sv | 156 +++++++++++++++
 tb/tb_mem_block_xfer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_block_xfer.sv
`default_nettype none
// ============================================================================
//  Module      : mem_block_xfer
//  Description : Splits whole-block fill/writeback requests into word-serial
//                memory accesses and reassembles fill data into one line.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_block_xfer #(
    parameter int BLOCK_ADDR_W    = 20,
    parameter int WORDS_PER_BLOCK = 16,
    parameter int WORD_W          = 32,
    parameter int OFF_W           = $clog2(WORDS_PER_BLOCK)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic                              req_write,
    input  logic [BLOCK_ADDR_W-1:0]           req_block_addr,
    input  logic [WORDS_PER_BLOCK*WORD_W-1:0] req_wdata,
    output logic                              resp_valid,
    input  logic                              resp_ready,
    output logic [WORDS_PER_BLOCK*WORD_W-1:0] resp_rdata,
    output logic                              mem_req_valid,
    input  logic                              mem_req_ready,
    output logic                              mem_we,
    output logic [BLOCK_ADDR_W+OFF_W-1:0]     mem_addr,
    output logic [WORD_W-1:0]                 mem_wdata,
    input  logic                              mem_rvalid,
    input  logic [WORD_W-1:0]                 mem_rdata,
    output logic                              err
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wr   = 2'd1;
    localparam logic [1:0] c_st_rd   = 2'd2;
    localparam logic [1:0] c_st_resp = 2'd3;

    localparam int               c_last_i  = WORDS_PER_BLOCK - 1;
    localparam int               c_words_i = WORDS_PER_BLOCK;
    localparam logic [OFF_W:0]   c_last    = c_last_i[OFF_W:0];
    localparam logic [OFF_W:0]   c_words   = c_words_i[OFF_W:0];

    logic [1:0]                       r_state;
    logic [1:0]                       w_next;
    logic [BLOCK_ADDR_W-1:0]          r_addr;
    logic [WORDS_PER_BLOCK*WORD_W-1:0] r_wbuf;
    logic [WORDS_PER_BLOCK*WORD_W-1:0] r_line;
    logic [OFF_W:0]                   r_issue_cnt;
    logic [OFF_W:0]                   r_ret_cnt;
    logic                             r_err;

    logic                             w_accept;
    logic                             w_issue;
    logic                             w_ret_ok;
    logic                             w_spur;
    logic [OFF_W-1:0]                 w_issue_idx;
    logic [OFF_W-1:0]                 w_ret_idx;

    assign w_issue_idx = r_issue_cnt[OFF_W-1:0];
    assign w_ret_idx   = r_ret_cnt[OFF_W-1:0];
    assign w_accept    = req_valid && req_ready;
    assign w_issue     = mem_req_valid && mem_req_ready;
    // A return is only legal while a fill has reads outstanding
    assign w_ret_ok    = (r_state == c_st_rd) && mem_rvalid && (r_issue_cnt != r_ret_cnt);
    assign w_spur      = mem_rvalid && !w_ret_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        mem_req_valid = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        case (r_state)
            c_st_idle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next = req_write ? c_st_wr : c_st_rd;
                end
            end
            c_st_wr: begin
                mem_req_valid = 1'b1;
                mem_we        = 1'b1;
                mem_addr      = {r_addr, w_issue_idx};
                mem_wdata     = r_wbuf[w_issue_idx*WORD_W +: WORD_W];
                if (mem_req_ready && (r_issue_cnt == c_last)) begin
                    w_next = c_st_resp;
                end
            end
            c_st_rd: begin
                mem_req_valid = (r_issue_cnt != c_words);
                if (mem_req_valid) begin
                    mem_addr = {r_addr, w_issue_idx};
                end
                if (w_ret_ok && (r_ret_cnt == c_last)) begin
                    w_next = c_st_resp;
                end
            end
            c_st_resp: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_next = c_st_idle;
                end
            end
            default: w_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_wbuf      <= '0;
            r_line      <= '0;
            r_issue_cnt <= '0;
            r_ret_cnt   <= '0;
        end else if (w_accept) begin
            // Line is cleared here so writebacks respond with all-zero data
            r_addr      <= req_block_addr;
            r_wbuf      <= req_wdata;
            r_line      <= '0;
            r_issue_cnt <= '0;
            r_ret_cnt   <= '0;
        end else begin
            if (w_issue) begin
                r_issue_cnt <= r_issue_cnt + 1'b1;
            end
            if (w_ret_ok) begin
                r_line[w_ret_idx*WORD_W +: WORD_W] <= mem_rdata;
                r_ret_cnt <= r_ret_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_spur) begin
            r_err <= 1'b1;
        end
    end

    assign resp_rdata = r_line;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_block_xfer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_block_xfer
//  Description : Directed self-checking bench for mem_block_xfer with a
//                word-memory model (returns {addr, 8'hA5}) and stall control.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_block_xfer;

    localparam int LW = 512;

    logic           clk = 1'b0;
    logic           rst;
    logic           req_valid;
    logic           req_ready;
    logic           req_write;
    logic [19:0]    req_block_addr;
    logic [LW-1:0]  req_wdata;
    logic           resp_valid;
    logic           resp_ready;
    logic [LW-1:0]  resp_rdata;
    logic           mem_req_valid;
    logic           mem_req_ready;
    logic           mem_we;
    logic [23:0]    mem_addr;
    logic [31:0]    mem_wdata;
    logic           mem_rvalid;
    logic [31:0]    mem_rdata;
    logic           err;

    mem_block_xfer dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_block_addr (req_block_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (resp_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .err            (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // memory model state
    logic [23:0] acc_addr[$];
    logic [31:0] acc_data[$];
    logic        acc_we[$];
    int          pend_due[$];
    logic [23:0] pend_addr[$];
    int          rets;
    int          max_out;
    int          stall_err;
    bit          rand_mode;
    bit          spur;
    logic        hold_v;
    logic [23:0] hold_addr;
    logic [31:0] hold_data;
    logic        hold_we;

    initial begin
        mem_req_ready = 1'b0;
        mem_rvalid    = 1'b0;
        mem_rdata     = '0;
        rets = 0; max_out = 0; stall_err = 0; rand_mode = 0; spur = 0; hold_v = 0;
        hold_addr = '0; hold_data = '0; hold_we = 0;
        forever begin
            @(posedge clk);
            #1;
            mem_req_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            mem_rvalid    = 1'b0;
            mem_rdata     = '0;
            if (spur) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'hBAD0BAD0;
                spur       = 0;
            end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = {pend_addr[0], 8'hA5};
                void'(pend_due.pop_front());
                void'(pend_addr.pop_front());
            end
            @(negedge clk);
            if (mem_rvalid) rets++;
            if (rst) begin
                hold_v = 0;
            end else begin
                if (hold_v && (!mem_req_valid || mem_addr !== hold_addr ||
                               mem_wdata !== hold_data || mem_we !== hold_we))
                    stall_err++;
                hold_v    = mem_req_valid && !mem_req_ready;
                hold_addr = mem_addr;
                hold_data = mem_wdata;
                hold_we   = mem_we;
                if (mem_req_valid && mem_req_ready) begin
                    acc_addr.push_back(mem_addr);
                    acc_data.push_back(mem_wdata);
                    acc_we.push_back(mem_we);
                    if (!mem_we) begin
                        pend_due.push_back(cyc + (rand_mode ? int'($urandom_range(1, 5)) : 1));
                        pend_addr.push_back(mem_addr);
                    end
                end
                if (pend_due.size() > max_out) max_out = pend_due.size();
            end
        end
    end

    function automatic logic [LW-1:0] exp_line(input logic [19:0] b);
        logic [LW-1:0] l;
        for (int k = 0; k < 16; k++) l[k*32 +: 32] = {b, 4'(k), 8'hA5};
        return l;
    endfunction

    // Called at a negedge; returns the cycle index of the accepting edge
    task automatic send_req(input logic w, input logic [19:0] a, input logic [LW-1:0] d,
                            output int acc);
        int t;
        acc_addr.delete(); acc_data.delete(); acc_we.delete();
        rets = 0; max_out = 0; stall_err = 0;
        req_valid = 1'b1; req_write = w; req_block_addr = a; req_wdata = d;
        t = 0;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t == 50) check("req_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        acc = cyc;
        req_valid = 1'b0; req_write = ~w; req_block_addr = ~a; req_wdata = ~d;
    endtask

    task automatic wait_resp(input int a, output int n);
        n = -1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (resp_valid) begin
                n = cyc - a + 1;
                return;
            end
        end
        check("resp_timeout", 0, 1);
    endtask

    task automatic handshake();
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, n, hs, bad;
        logic [LW-1:0] d, snap;

        rst = 1'b1; req_valid = 0; req_write = 0; req_block_addr = '0; req_wdata = '0;
        resp_ready = 0;
        repeat (2) @(negedge clk);
        check("reset_ctrl", {req_ready, resp_valid, mem_req_valid, mem_we, err}, 5'b10000);
        check("reset_rdata", resp_rdata, '0);
        rst = 1'b0;
        @(negedge clk);

        // read fill, zero-stall
        send_req(1'b0, 20'h00003, '0, a);
        wait_resp(a, n);
        check("rd_latency", n, 18);
        check("rd_beats", acc_addr.size(), 16);
        for (int k = 0; k < 16 && k < acc_addr.size(); k++)
            check($sformatf("rd_addr%0d", k), {acc_we[k], acc_addr[k]}, {1'b0, 20'h00003, 4'(k)});
        check("rd_line", resp_rdata, exp_line(20'h00003));
        check("rd_err", err, 0);
        handshake();
        check("rd_req_ready_after", req_ready, 1);

        // writeback to all-ones block
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = 32'hDEAD0000 + k;
        send_req(1'b1, 20'hFFFFF, d, a);
        wait_resp(a, n);
        check("wr_latency", n, 17);
        check("wr_beats", acc_addr.size(), 16);
        for (int k = 0; k < 16 && k < acc_addr.size(); k++)
            check($sformatf("wr_beat%0d", k), {acc_we[k], acc_addr[k], acc_data[k]},
                  {1'b1, 20'hFFFFF, 4'(k), 32'hDEAD0000 + k});
        check("wr_rdata_zero", resp_rdata, '0);
        handshake();

        // stalls and variable latency
        rand_mode = 1;
        send_req(1'b0, 20'h12345, '0, a);
        wait_resp(a, n);
        check("st_rd_line", resp_rdata, exp_line(20'h12345));
        check("st_rd_stable", stall_err, 0);
        check("st_rd_outstanding", max_out <= 16, 1);
        handshake();
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
        send_req(1'b1, 20'h00ABC, d, a);
        wait_resp(a, n);
        for (int k = 0; k < 16 && k < acc_addr.size(); k++)
            check($sformatf("st_wr_beat%0d", k), {acc_addr[k], acc_data[k]},
                  {20'h00ABC, 4'(k), d[k*32 +: 32]});
        check("st_wr_stable", stall_err, 0);
        handshake();
        rand_mode = 0;

        // resp held off, then back-to-back request
        send_req(1'b0, 20'h00040, '0, a);
        wait_resp(a, n);
        snap = resp_rdata;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!resp_valid || resp_rdata !== snap || req_ready) bad++;
        end
        check("hold_stable", bad, 0);
        check("hold_line", snap, exp_line(20'h00040));
        handshake();
        hs = cyc;
        check("b2b_req_ready", req_ready, 1);
        send_req(1'b1, 20'h00041, d, a);
        check("b2b_accept_cycle", a, hs + 1);
        wait_resp(a, n);
        handshake();

        // reset mid-transfer after 7 returns
        send_req(1'b0, 20'h00007, '0, a);
        bad = 1;
        for (int t = 0; t < 100; t++) begin
            @(posedge clk);
            #3;
            if (rets >= 7) begin
                bad = 0;
                break;
            end
        end
        check("rst_wait_rets", bad, 0);
        rst = 1'b1;
        mem_rvalid = 1'b0;
        pend_due.delete(); pend_addr.delete();
        #1;
        check("rst_mid_ctrl", {req_ready, resp_valid, mem_req_valid, mem_we, err}, 5'b10000);
        check("rst_mid_addr", {mem_addr, mem_wdata}, '0);
        check("rst_mid_rdata", resp_rdata, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_req(1'b0, 20'h00010, '0, a);
        wait_resp(a, n);
        check("post_rst_latency", n, 18);
        check("post_rst_line", resp_rdata, exp_line(20'h00010));
        handshake();

        // spurious return while idle
        check("spur_err_before", err, 0);
        spur = 1;
        repeat (2) @(negedge clk);
        check("spur_err_set", err, 1);
        repeat (3) @(negedge clk);
        check("spur_err_sticky", err, 1);
        send_req(1'b0, 20'h00020, '0, a);
        wait_resp(a, n);
        check("spur_fill_line", resp_rdata, exp_line(20'h00020));
        check("spur_err_still", err, 1);
        handshake();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
